cargador_trabajo: RTL

Job loader that sits directly upstream of `sistema_speed`. It assembles a 13-byte job frame from a byte stream: a 96-bit payload, MSB byte first, followed by an 8-bit target. It then drives `payload`/`target`/`active` into the miner and holds `active` until `terminado` or a cycle-budget timeout. The captured nonce/hash result is presented on a valid/ready result port before the next frame is accepted.

---
 rtl/cargador_trabajo_pkg.sv | 18 +
 rtl/cargador_trabajo_if.sv | 30 +++
 rtl/cargador_trabajo_ensamblador_trama.sv | 37 +++
 rtl/cargador_trabajo.sv | 72 +++++++
 4 files changed

// File: rtl/cargador_trabajo_pkg.sv
// Shared constants, state encoding and the result record for the job loader.
package cargador_pkg;
  localparam int FRAME_BYTES = 13;
  localparam int PAYLOAD_W   = 96;
  localparam int TARGET_W    = 8;
  localparam int NONCE_W     = 32;
  localparam int HASH_W      = 24;

  localparam logic [1:0] CARGA     = 2'd0;
  localparam logic [1:0] MINANDO   = 2'd1;
  localparam logic [1:0] RESULTADO = 2'd2;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
    logic               timeout;
  } resultado_t;
endpackage

// File: rtl/cargador_trabajo_if.sv
// Byte-stream, miner and result signals of the job loader.
interface cargador_trabajo_if;
  import cargador_pkg::*;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic [PAYLOAD_W-1:0] payload;
  logic [TARGET_W-1:0]  target;
  logic                 active;
  logic                 terminado;
  logic [NONCE_W-1:0]   nonceIn;
  logic [HASH_W-1:0]    hashIn;
  logic                 res_valid;
  logic                 res_ready;
  logic [NONCE_W-1:0]   res_nonce;
  logic [HASH_W-1:0]    res_hash;
  logic                 res_timeout;
  logic [15:0]          trabajos;

  modport slave (
    input  in_valid, in_data, terminado, nonceIn, hashIn, res_ready,
    output in_ready, payload, target, active, res_valid, res_nonce, res_hash,
           res_timeout, trabajos
  );
  modport master (
    output in_valid, in_data, terminado, nonceIn, hashIn, res_ready,
    input  in_ready, payload, target, active, res_valid, res_nonce, res_hash,
           res_timeout, trabajos
  );
endinterface

// File: rtl/cargador_trabajo_ensamblador_trama.sv
// Frame assembler: 12 payload bytes MSB first, then the target byte.
module ensamblador_trama
  import cargador_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 carga,
  input  logic                 clr,
  input  logic [7:0]           dato,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [TARGET_W-1:0]  target,
  output logic                 trama_lista
);
  localparam logic [3:0] IDX_ULT = 4'(FRAME_BYTES - 1);

  logic [3:0] idx;

  assign trama_lista = carga && (idx == IDX_ULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      payload <= '0;
      target  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (carga) begin
      if (idx == IDX_ULT) begin
        target <= dato;
        idx    <= '0;
      end else begin
        payload <= {payload[PAYLOAD_W-9:0], dato};
        idx     <= idx + 4'd1;
      end
    end
  end
endmodule

// File: rtl/cargador_trabajo.sv
// Job loader: assembles a frame, runs the miner with a cycle budget and
// holds the result on a valid/ready port until it is taken.
module cargador_trabajo
  import cargador_pkg::*;
#(
  parameter logic [31:0] MAX_CICLOS = 32'hFFFF_FFFF,
  parameter int          CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  cargador_trabajo_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(MAX_CICLOS - 32'd1);

  logic [1:0]       estado;
  logic [CNT_W-1:0] cnt;
  resultado_t       res_q;
  logic [15:0]      trabajos_q;
  logic             carga, trama_lista, handshake;

  assign bus.in_ready    = (estado == CARGA);
  assign bus.active      = (estado == MINANDO);
  assign bus.res_valid   = (estado == RESULTADO);
  assign bus.res_nonce   = res_q.nonce;
  assign bus.res_hash    = res_q.hash;
  assign bus.res_timeout = res_q.timeout;
  assign bus.trabajos    = trabajos_q;

  assign carga     = bus.in_valid & bus.in_ready;
  assign handshake = bus.res_valid & bus.res_ready;

  ensamblador_trama u_trama (
    .clk         (clk),
    .reset       (reset),
    .carga       (carga),
    .clr         (handshake),
    .dato        (bus.in_data),
    .payload     (bus.payload),
    .target      (bus.target),
    .trama_lista (trama_lista)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= CARGA;
      cnt        <= '0;
      res_q      <= '0;
      trabajos_q <= '0;
    end else begin
      case (estado)
        CARGA: if (trama_lista) estado <= MINANDO;
        MINANDO: begin
          cnt <= cnt + 1'b1;
          // terminado takes priority over a timeout in the same cycle
          if (bus.terminado) begin
            res_q  <= '{nonce: bus.nonceIn, hash: bus.hashIn, timeout: 1'b0};
            estado <= RESULTADO;
          end else if (cnt == CNT_FIN) begin
            res_q  <= '{nonce: '0, hash: '0, timeout: 1'b1};
            estado <= RESULTADO;
          end
        end
        RESULTADO: if (bus.res_ready) begin
          trabajos_q <= trabajos_q + 16'd1;
          cnt        <= '0;
          estado     <= CARGA;
        end
        default: estado <= CARGA;
      endcase
    end
  end
endmodule
